// File: rtl/bit_serial_feeder.sv
// bit_serial_feeder
//
// Turns 8-bit activation words and 8-bit weight words into the bit-serial
// control stream of a MAC array.
//   - A weight word is shifted out LSB first over 8 cycles with update_w high.
//   - An activation word is streamed LSB first over SER_LEN cycles with mac_en
//     high. Bits 8 and above are zero padding that lets the accumulator settle.
//   - Negated words run the two's-complement path: control1 low for the whole
//     word and a +1 injection (plus_one) on the first bit.
//   - clear_accu_control marks the first word of each dot product.
//   - vec_done pulses once after the final bit of a word tagged act_last.
//
// Handshake: a word moves only on a rising clk edge where its valid and ready
// are both high. Ready depends only on the current state (and on w_valid_i in
// IDLE, where a pending weight has priority over an activation). Ready never
// depends on the same channel's valid.
//
// Ports
//   clk_i                 clock; every state change is on its rising edge
//   rst_ni                asynchronous active-low reset
//   act_valid_i/ready_o   activation handshake
//   act_data_i [7:0]      activation magnitude, unsigned
//   act_neg_i             activation is negated
//   act_last_i            activation closes a dot product
//   w_valid_i/w_ready_o   weight handshake
//   w_data_i [7:0]        weight word
//   dataflow_in_o         serial bit to the MAC array (registered)
//   mac_en_o              MAC advance enable (registered)
//   update_w_o            MAC weight shift enable (registered)
//   plus_one_o            two's-complement +1 injection (registered)
//   control1_o            1 = positive path, 0 = negated path (registered)
//   clear_accu_control_o  first bit of a new dot product (registered)
//   vec_done_o            one-cycle end-of-vector pulse (registered)
//   state_o [1:0]         debug: FSM state (0 IDLE, 1 WLOAD, 2 STREAM)
//   bit_cnt_o [5:0]       debug: bit position inside the current word
module bit_serial_feeder #(
    parameter int SER_LEN = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       act_valid_i,
    input  logic [7:0] act_data_i,
    input  logic       act_neg_i,
    input  logic       act_last_i,
    output logic       act_ready_o,
    input  logic       w_valid_i,
    input  logic [7:0] w_data_i,
    output logic       w_ready_o,
    output logic       dataflow_in_o,
    output logic       mac_en_o,
    output logic       update_w_o,
    output logic       plus_one_o,
    output logic       control1_o,
    output logic       clear_accu_control_o,
    output logic       vec_done_o,
    output logic [1:0] state_o,
    output logic [5:0] bit_cnt_o
);

    localparam int WEIGHT_BITS = 8;
    localparam logic [5:0] CNT_LAST  = 6'(SER_LEN - 1);
    localparam logic [5:0] WCNT_LAST = 6'(WEIGHT_BITS - 1);
    localparam logic [5:0] DATA_BITS = 6'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WLOAD  = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    // State and captured words
    state_e                   state_q, state_d;
    logic [5:0]               bit_cnt_q, bit_cnt_d;
    logic [WEIGHT_BITS-1:0]   w_word_q, w_word_d;
    logic [7:0]               act_data_q, act_data_d;
    logic                     act_neg_q, act_neg_d;
    logic                     act_last_q, act_last_d;
    logic                     first_q, first_d;

    // Registered outputs
    logic dataflow_q, dataflow_d;
    logic mac_en_q, mac_en_d;
    logic update_w_q, update_w_d;
    logic plus_one_q, plus_one_d;
    logic control1_q, control1_d;
    logic clear_q, clear_d;
    logic vec_done_q, vec_done_d;

    // Handshake and sequencing helpers
    logic cnt_at_end;
    logic act_ready;
    logic w_ready;
    logic act_fire;
    logic w_fire;
    logic start_word;
    logic start_clear;

    assign cnt_at_end = (bit_cnt_q == CNT_LAST);

    // In IDLE a pending weight wins, so act_ready drops while w_valid_i is high.
    // In STREAM the next word may only enter on the final bit, which gives
    // gap-free back-to-back streaming.
    assign act_ready = ((state_q == ST_IDLE) && !w_valid_i) ||
                       ((state_q == ST_STREAM) && cnt_at_end);
    assign w_ready   = (state_q == ST_IDLE);
    assign act_fire  = act_valid_i && act_ready;
    assign w_fire    = w_valid_i && w_ready;

    // Next-state logic. The outputs are registered, so each branch computes
    // what the array must see in the cycle after this edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        w_word_d    = w_word_q;
        act_data_d  = act_data_q;
        act_neg_d   = act_neg_q;
        act_last_d  = act_last_q;
        first_d     = first_q;
        dataflow_d  = 1'b0;
        mac_en_d    = 1'b0;
        update_w_d  = 1'b0;
        plus_one_d  = 1'b0;
        control1_d  = 1'b1;
        clear_d     = 1'b0;
        vec_done_d  = 1'b0;
        start_word  = 1'b0;
        start_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_fire) begin
                    state_d    = ST_WLOAD;
                    bit_cnt_d  = 6'd0;
                    w_word_d   = w_data_i;
                    dataflow_d = w_data_i[0];
                    update_w_d = 1'b1;
                end else if (act_fire) begin
                    start_word  = 1'b1;
                    start_clear = first_q;
                end
            end

            ST_WLOAD: begin
                if (bit_cnt_q == WCNT_LAST) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 6'd0;
                end else begin
                    bit_cnt_d  = bit_cnt_q + 6'd1;
                    dataflow_d = w_word_q[bit_cnt_d[2:0]];
                    update_w_d = 1'b1;
                end
            end

            ST_STREAM: begin
                if (cnt_at_end) begin
                    // Word finished: close the vector if it was tagged last.
                    vec_done_d = act_last_q;
                    first_d    = act_last_q;
                    if (act_fire) begin
                        // A follow-on word starts a new vector exactly when the
                        // word just finished was the last of the old one.
                        start_word  = 1'b1;
                        start_clear = act_last_q;
                    end else begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = 6'd0;
                    end
                end else begin
                    bit_cnt_d  = bit_cnt_q + 6'd1;
                    mac_en_d   = 1'b1;
                    control1_d = ~act_neg_q;
                    // Bits beyond the 8-bit magnitude are zero padding.
                    dataflow_d = (bit_cnt_d < DATA_BITS) ? act_data_q[bit_cnt_d[2:0]] : 1'b0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 6'd0;
            end
        endcase

        // Shared entry into STREAM, from IDLE or straight off the final bit.
        if (start_word) begin
            state_d    = ST_STREAM;
            bit_cnt_d  = 6'd0;
            act_data_d = act_data_i;
            act_neg_d  = act_neg_i;
            act_last_d = act_last_i;
            first_d    = 1'b0;
            dataflow_d = act_data_i[0];
            mac_en_d   = 1'b1;
            plus_one_d = act_neg_i;
            control1_d = ~act_neg_i;
            clear_d    = start_clear;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 6'd0;
            w_word_q   <= '0;
            act_data_q <= 8'd0;
            act_neg_q  <= 1'b0;
            act_last_q <= 1'b0;
            first_q    <= 1'b1;
            dataflow_q <= 1'b0;
            mac_en_q   <= 1'b0;
            update_w_q <= 1'b0;
            plus_one_q <= 1'b0;
            control1_q <= 1'b1;
            clear_q    <= 1'b0;
            vec_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            w_word_q   <= w_word_d;
            act_data_q <= act_data_d;
            act_neg_q  <= act_neg_d;
            act_last_q <= act_last_d;
            first_q    <= first_d;
            dataflow_q <= dataflow_d;
            mac_en_q   <= mac_en_d;
            update_w_q <= update_w_d;
            plus_one_q <= plus_one_d;
            control1_q <= control1_d;
            clear_q    <= clear_d;
            vec_done_q <= vec_done_d;
        end
    end

    assign act_ready_o          = act_ready;
    assign w_ready_o            = w_ready;
    assign dataflow_in_o        = dataflow_q;
    assign mac_en_o             = mac_en_q;
    assign update_w_o           = update_w_q;
    assign plus_one_o           = plus_one_q;
    assign control1_o           = control1_q;
    assign clear_accu_control_o = clear_q;
    assign vec_done_o           = vec_done_q;
    assign state_o              = state_q;
    assign bit_cnt_o            = bit_cnt_q;

endmodule

// File: tb/tb_bit_serial_feeder.sv
// Directed bench for bit_serial_feeder. Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, so every sample reflects
// the edge just taken.
module tb_bit_serial_feeder;

    localparam int SER_LEN = 16;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT connections
    logic       act_valid = 1'b0;
    logic [7:0] act_data  = 8'd0;
    logic       act_neg   = 1'b0;
    logic       act_last  = 1'b0;
    logic       act_ready;
    logic       w_valid   = 1'b0;
    logic [7:0] w_data    = 8'd0;
    logic       w_ready;
    logic       dataflow_in, mac_en, update_w, plus_one, control1;
    logic       clear_accu, vec_done;
    logic [1:0] state;
    logic [5:0] bit_cnt;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    bit_serial_feeder #(.SER_LEN(SER_LEN)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .act_valid_i          (act_valid),
        .act_data_i           (act_data),
        .act_neg_i            (act_neg),
        .act_last_i           (act_last),
        .act_ready_o          (act_ready),
        .w_valid_i            (w_valid),
        .w_data_i             (w_data),
        .w_ready_o            (w_ready),
        .dataflow_in_o        (dataflow_in),
        .mac_en_o             (mac_en),
        .update_w_o           (update_w),
        .plus_one_o           (plus_one),
        .control1_o           (control1),
        .clear_accu_control_o (clear_accu),
        .vec_done_o           (vec_done),
        .state_o              (state),
        .bit_cnt_o            (bit_cnt)
    );

    // Driver / checker tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Idle-state output values.
    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, {6'd0, state}, 8'd0);
        chk({tag, "_mac_en"}, {7'd0, mac_en}, 8'd0);
        chk({tag, "_update_w"}, {7'd0, update_w}, 8'd0);
        chk({tag, "_df"}, {7'd0, dataflow_in}, 8'd0);
        chk({tag, "_plus_one"}, {7'd0, plus_one}, 8'd0);
        chk({tag, "_control1"}, {7'd0, control1}, 8'd1);
        chk({tag, "_clear"}, {7'd0, clear_accu}, 8'd0);
    endtask

    // Expects bit 0 of a word already visible; checks all SER_LEN cycles and
    // returns with the cycle after the final bit visible.
    task automatic run_stream(input string tag, input logic [7:0] d, input logic neg,
                              input logic clr);
        logic eb;
        for (int k = 0; k < SER_LEN; k++) begin
            eb = (k < 8) ? d[k] : 1'b0;
            chk($sformatf("%s_mac_en_%0d", tag, k), {7'd0, mac_en}, 8'd1);
            chk($sformatf("%s_df_%0d", tag, k), {7'd0, dataflow_in}, {7'd0, eb});
            chk($sformatf("%s_clear_%0d", tag, k), {7'd0, clear_accu}, {7'd0, (k == 0) ? clr : 1'b0});
            chk($sformatf("%s_plus_one_%0d", tag, k), {7'd0, plus_one}, {7'd0, (k == 0) ? neg : 1'b0});
            chk($sformatf("%s_control1_%0d", tag, k), {7'd0, control1}, {7'd0, ~neg});
            chk($sformatf("%s_update_w_%0d", tag, k), {7'd0, update_w}, 8'd0);
            chk($sformatf("%s_state_%0d", tag, k), {6'd0, state}, 8'd2);
            chk($sformatf("%s_act_ready_%0d", tag, k), {7'd0, act_ready},
                {7'd0, (k == SER_LEN - 1) ? 1'b1 : 1'b0});
            if (k > 0) chk($sformatf("%s_vec_done_%0d", tag, k), {7'd0, vec_done}, 8'd0);
            tick();
        end
    endtask

    // Expects weight bit 0 visible; returns with the cycle after bit 7 visible.
    task automatic run_wload(input string tag, input logic [7:0] w);
        logic [0:0] eb;
        for (int k = 0; k < 8; k++) exp_q.push_back(w[k]);
        for (int k = 0; k < 8; k++) begin
            eb = exp_q.pop_front();
            chk($sformatf("%s_update_w_%0d", tag, k), {7'd0, update_w}, 8'd1);
            chk($sformatf("%s_df_%0d", tag, k), {7'd0, dataflow_in}, {7'd0, eb});
            chk($sformatf("%s_mac_en_%0d", tag, k), {7'd0, mac_en}, 8'd0);
            chk($sformatf("%s_state_%0d", tag, k), {6'd0, state}, 8'd1);
            chk($sformatf("%s_w_ready_%0d", tag, k), {7'd0, w_ready}, 8'd0);
            chk($sformatf("%s_act_ready_%0d", tag, k), {7'd0, act_ready}, 8'd0);
            tick();
        end
    endtask

    task automatic send_act(input logic [7:0] d, input logic neg, input logic last);
        act_data  = d;
        act_neg   = neg;
        act_last  = last;
        act_valid = 1'b1;
        tick();
        act_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset_vec_done", {7'd0, vec_done}, 8'd0);
        chk("reset_bit_cnt", {2'd0, bit_cnt}, 8'd0);
        chk("reset_act_ready", {7'd0, act_ready}, 8'd1);
        chk("reset_w_ready", {7'd0, w_ready}, 8'd1);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_act_ready", {7'd0, act_ready}, 8'd1);
        chk("post_rst_w_ready", {7'd0, w_ready}, 8'd1);

        // Single word 0x05, last: first of vector after reset
        send_act(8'h05, 1'b0, 1'b1);
        chk("w05_vec_done_0", {7'd0, vec_done}, 8'd0);
        run_stream("w05", 8'h05, 1'b0, 1'b1);
        chk_idle("w05_end");
        chk("w05_vec_done", {7'd0, vec_done}, 8'd1);
        tick();
        chk("w05_vec_done_off", {7'd0, vec_done}, 8'd0);

        // Weight 0xA3
        w_data  = 8'hA3;
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        run_wload("wA3", 8'hA3);
        chk_idle("wA3_end");

        // Back-to-back 0x81 (last=0) then 0x7F (last=1), act_valid held high;
        // the inputs change right after the first acceptance.
        act_data  = 8'h81;
        act_neg   = 1'b0;
        act_last  = 1'b0;
        act_valid = 1'b1;
        tick();
        act_data  = 8'h7F;
        act_last  = 1'b1;
        run_stream("b81", 8'h81, 1'b0, 1'b1);
        act_valid = 1'b0;
        chk("b7f_vec_done_0", {7'd0, vec_done}, 8'd0);
        run_stream("b7f", 8'h7F, 1'b0, 1'b0);
        chk_idle("b7f_end");
        chk("b7f_vec_done", {7'd0, vec_done}, 8'd1);
        tick();
        chk("b7f_vec_done_off", {7'd0, vec_done}, 8'd0);

        // Negated word 0x03
        send_act(8'h03, 1'b1, 1'b1);
        run_stream("n03", 8'h03, 1'b1, 1'b1);
        chk_idle("n03_end");
        chk("n03_vec_done", {7'd0, vec_done}, 8'd1);

        // Weight and activation offered together: weight goes first
        tick();
        w_data    = 8'h5A;
        w_valid   = 1'b1;
        act_data  = 8'hC4;
        act_neg   = 1'b0;
        act_last  = 1'b0;
        act_valid = 1'b1;
        #1;
        chk("both_act_ready", {7'd0, act_ready}, 8'd0);
        chk("both_w_ready", {7'd0, w_ready}, 8'd1);
        tick();
        w_valid = 1'b0;
        run_wload("w5A", 8'h5A);
        chk_idle("w5A_end");
        chk("w5A_act_ready", {7'd0, act_ready}, 8'd1);
        tick();
        act_valid = 1'b0;
        run_stream("aC4", 8'hC4, 1'b0, 1'b1);
        chk_idle("aC4_end");
        chk("aC4_vec_done", {7'd0, vec_done}, 8'd0);

        // Reset in the middle of a stream (continuation word, so no clear)
        send_act(8'h33, 1'b0, 1'b1);
        chk("r33_clear_0", {7'd0, clear_accu}, 8'd0);
        repeat (5) tick();
        chk("r33_bit_cnt_5", {2'd0, bit_cnt}, 8'd5);
        chk("r33_df_5", {7'd0, dataflow_in}, 8'd1);
        chk("r33_mac_en_5", {7'd0, mac_en}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("r33_async");
        chk("r33_async_bit_cnt", {2'd0, bit_cnt}, 8'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("r33_hold_mac_en_%0d", k), {7'd0, mac_en}, 8'd0);
            chk($sformatf("r33_hold_vec_done_%0d", k), {7'd0, vec_done}, 8'd0);
        end
        #3 rst_n = 1'b1;
        tick();
        chk_idle("r33_released");
        chk("r33_released_vec_done", {7'd0, vec_done}, 8'd0);

        // First word after reset clears the accumulator again
        send_act(8'h01, 1'b0, 1'b1);
        run_stream("p01", 8'h01, 1'b0, 1'b1);
        chk_idle("p01_end");
        chk("p01_vec_done", {7'd0, vec_done}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serial_feeder.md
BIT_SERIAL_FEEDER -- requirements
Module: bit_serial_feeder

Interface
REQ-001 SER_LEN, 16, total mac_en cycles per activation word; legal range 9..63.
REQ-002 WEIGHT_BITS, 8, width of the weight word shifted out on update_w; fixed at 8.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 act_valid  in  1  upstream offers an activation word.
REQ-006 act_data  in  8  activation magnitude, unsigned.
REQ-007 act_neg  in  1  word is negated (two's-complement path in the MAC).
REQ-008 act_last  in  1  word is the final element of a dot product.
REQ-009 act_ready  out  1  feeder accepts the word this cycle.
REQ-010 w_valid  in  1  upstream offers a weight word.
REQ-011 w_data  in  8  weight word.
REQ-012 w_ready  out  1  feeder accepts the weight this cycle.
REQ-013 dataflow_in  out  1  serial bit to the MAC array.
REQ-014 mac_en  out  1  MAC advance enable.
REQ-015 update_w  out  1  MAC weight shift enable.
REQ-016 plus_one  out  1  two's-complement +1 injection.
REQ-017 control1  out  1  1 = positive path, 0 = negated path.
REQ-018 clear_accu_control  out  1  start of a new dot product.
REQ-019 vec_done  out  1  one-cycle pulse when the last bit of an act_last word has been issued.

Function
REQ-020 A word transfers only on cycles where valid and ready are both high at the rising clk edge.
REQ-021 The state machine has three states: IDLE, WLOAD and STREAM.
REQ-022 w_ready is high only in IDLE; act_ready is high in IDLE and also in STREAM when bit_cnt == SER_LEN-1; otherwise both are low.
REQ-023 In IDLE, when w_valid and act_valid are both high, the weight is accepted, act_ready is forced low that cycle, and the state moves to WLOAD.
REQ-024 WLOAD lasts exactly 8 cycles: update_w=1; dataflow_in = w_data bit k in cycle k, LSB first; mac_en=0.
REQ-025 After WLOAD the state returns to IDLE.
REQ-026 An accepted activation enters STREAM on the next cycle, bit_cnt=0.
REQ-027 STREAM lasts exactly SER_LEN cycles with mac_en=1.
REQ-028 In STREAM, dataflow_in = act_data bit k for k<8 (LSB first) and 0 for k>=8.
REQ-029 plus_one is 1 only at bit_cnt==0 of a word with act_neg=1.
REQ-030 control1 = ~act_neg for all SER_LEN cycles of the word.
REQ-031 clear_accu_control is 1 only at bit_cnt==0 of the first word of a vector, i.e. the first word after reset or after an act_last word.
REQ-032 An activation accepted at bit_cnt==SER_LEN-1 streams with no bubble: the next cycle is bit_cnt==0 of the new word.
REQ-033 If no activation is accepted at bit_cnt==SER_LEN-1, the state returns to IDLE.
REQ-034 vec_done pulses in the cycle after bit SER_LEN-1 of an act_last word.
REQ-035 act_data, act_neg and act_last are captured at acceptance; input changes during STREAM have no effect.
REQ-036 dataflow_in, mac_en, update_w, plus_one, control1, clear_accu_control and vec_done are registered outputs.
REQ-037 Outputs are first visible the cycle after the acceptance edge, so latency from acceptance to first bit is 1 cycle.
REQ-038 Outside WLOAD and STREAM: mac_en=update_w=plus_one=clear_accu_control=0, dataflow_in=0, control1=1.
REQ-039 bit_cnt is 6 bits and wraps to 0 after SER_LEN-1; no other wrap is permitted.

Reset
REQ-040 Asserting reset asynchronously forces: state=IDLE, bit_cnt=0, all registered outputs 0 except control1=1, and first-of-vector flag=1.
REQ-041 Reset mid-WLOAD or mid-STREAM aborts the word with no further mac_en or update_w pulses; vec_done is not emitted.
REQ-042 After reset deassertion, act_ready=w_ready=1 from the first clk edge.

Verification
REQ-043 Reset, then send act_data=0x05, neg=0, last=1 -> 16 mac_en cycles; dataflow_in=1,0,1,0,0... ; clear_accu_control at cycle 0 only; vec_done one cycle after cycle 15.
REQ-044 Send w_data=0xA3 -> update_w high for 8 cycles with dataflow_in=1,1,0,0,0,1,0,1; mac_en stays 0.
REQ-045 Send back-to-back words 0x81 (last=0) and 0x7F (last=1) with act_valid held high -> 32 contiguous mac_en cycles; clear_accu_control only at cycle 0; vec_done once.
REQ-046 Send act_neg=1, data=0x03 -> plus_one only at cycle 0; control1=0 for all 16 cycles, returning to 1 afterwards.
REQ-047 Hold w_valid and act_valid high in IDLE -> the weight is loaded first (8 cycles), then the activation is accepted.
REQ-048 Assert reset at STREAM cycle 5 -> all outputs reach reset values immediately; the next word after release gets clear_accu_control=1.
